// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch control slice: FSM encoding and PC arithmetic.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic [31:0] pc_add4(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: next-PC mux, instruction memory and IF/ID handshake toward decode.
interface fetch_if;
  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pcplus4;
  logic        ifid_ready;

  modport master (
    input  next_pc, redirect, stall, imem_ack, imem_data, ifid_ready,
    output pc_plus4, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pcplus4
  );

  modport slave (
    output next_pc, redirect, stall, imem_ack, imem_data, ifid_ready,
    input  pc_plus4, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pcplus4
  );
endinterface

// File: rtl/ifid_reg.sv
// Single-entry IF/ID pipeline register; load wins over clear, clear only drops the valid bit.
module ifid_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_p0,
  input  logic [31:0] pcplus4_p0,
  output logic        vld_p1,
  output logic [31:0] instr_p1,
  output logic [31:0] pcplus4_p1
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      instr_p1   <= '0;
      pcplus4_p1 <= '0;
    end else if (load) begin
      vld_p1     <= 1'b1;
      instr_p1   <= instr_p0;
      pcplus4_p1 <= pcplus4_p0;
    end else if (clear) begin
      vld_p1     <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch control: owns the PC, runs the imem req/ack handshake and fills IF/ID.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master bus
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt, pc_plus4, imem_addr;
  logic         imem_req, ack, accept;
  logic         pc_load, ifid_load, ifid_clear;
  logic         ifid_vld;
  logic [31:0]  ifid_instr, ifid_pcplus4;

  assign ack    = bus.imem_ack & imem_req;
  assign accept = ifid_vld & bus.ifid_ready & ~bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Redirect dominates; an in-flight fetch with no ack must be drained in DISCARD
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    state_nxt = S_REQ;
      S_REQ: begin
        if (bus.redirect)  state_nxt = ack ? S_REQ : S_DISCARD;
        else if (ack)      state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (bus.redirect || accept) state_nxt = S_REQ;
      end
      S_DISCARD: begin
        if (!bus.redirect && ack) state_nxt = S_REQ;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    ifid_load = 1'b0;
    case (state)
      S_REQ: begin
        imem_req  = 1'b1;
        ifid_load = bus.imem_ack & ~bus.redirect;
      end
      S_DISCARD: imem_req = 1'b1;
      default:   imem_req = 1'b0;
    endcase
    ifid_clear = bus.redirect | accept;
    pc_load    = bus.redirect | ifid_load;
  end

  assign pc_nxt = pc_load ? bus.next_pc : pc;

  // Fetch address follows the PC except while a stale fetch is being drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      pc_plus4  <= pc_add4(RESET_PC);
      imem_addr <= RESET_PC;
    end else begin
      pc       <= pc_nxt;
      pc_plus4 <= pc_add4(pc_nxt);
      if (state_nxt != S_DISCARD) imem_addr <= pc_nxt;
    end
  end

  ifid_reg u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ifid_load),
    .clear      (ifid_clear),
    .instr_p0   (bus.imem_data),
    .pcplus4_p0 (pc_plus4),
    .vld_p1     (ifid_vld),
    .instr_p1   (ifid_instr),
    .pcplus4_p1 (ifid_pcplus4)
  );

  assign bus.imem_req     = imem_req;
  assign bus.imem_addr    = imem_addr;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.ifid_valid   = ifid_vld;
  assign bus.ifid_instr   = ifid_instr;
  assign bus.ifid_pcplus4 = ifid_pcplus4;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a transaction-level model of the fetch stage.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: has fetching begun, is the IF/ID entry occupied, is a dropped fetch still in flight
  logic        m_started, m_full, m_stale;
  logic [31:0] m_pc, m_stale_addr, m_instr, m_ifpc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_started = 1'b0; m_full = 1'b0; m_stale = 1'b0;
    m_pc = RESET_PC; m_stale_addr = RESET_PC; m_instr = '0; m_ifpc = '0;
  endtask

  task automatic check_outputs();
    logic exp_req;
    exp_req = m_started & ~m_full;
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
    if (exp_req || !m_started)
      chk("imem_addr", bus.imem_addr, m_stale ? m_stale_addr : m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("ifid_valid", {31'b0, bus.ifid_valid}, {31'b0, m_full});
    if (m_full) begin
      chk("ifid_instr", bus.ifid_instr, m_instr);
      chk("ifid_pcplus4", bus.ifid_pcplus4, m_ifpc);
    end
  endtask

  task automatic step_model(input logic a, input logic rd, input logic r, input logic s,
                            input logic [31:0] d, input logic [31:0] np);
    if (!m_started) begin
      m_started = 1'b1;
      if (rd) m_pc = np;
    end else if (m_full) begin
      if (rd) begin m_pc = np; m_full = 1'b0; end
      else if (r && !s) m_full = 1'b0;
    end else if (m_stale) begin
      if (rd) m_pc = np;
      else if (a) m_stale = 1'b0;
    end else begin
      if (rd) begin
        if (!a) begin m_stale = 1'b1; m_stale_addr = m_pc; end
        m_pc = np;
      end else if (a) begin
        m_instr = d; m_ifpc = m_pc + 32'd4; m_full = 1'b1; m_pc = np;
      end
    end
  endtask

  task automatic drive_and_step(input int ack_pct, input int rdy_pct, input int stall_pct,
                                input int redir_pct);
    logic a, r, s, rd;
    logic [31:0] d, tgt, np;
    a  = int'($urandom_range(99)) < ack_pct;
    r  = int'($urandom_range(99)) < rdy_pct;
    s  = int'($urandom_range(99)) < stall_pct;
    rd = int'($urandom_range(99)) < redir_pct;
    d  = $urandom();
    case ($urandom_range(2))
      0:       tgt = 32'h0000_0100;
      1:       tgt = 32'hFFFF_FFFC;
      default: tgt = $urandom() & 32'hFFFF_FFFC;
    endcase
    np = rd ? tgt : m_pc + 32'd4;
    bus.imem_ack = a; bus.ifid_ready = r; bus.stall = s; bus.redirect = rd;
    bus.imem_data = d; bus.next_pc = np;
    step_model(a, rd, r, s, d, np);
  endtask

  task automatic cycle(input int ack_pct, input int rdy_pct, input int stall_pct,
                       input int redir_pct);
    @(negedge clk);
    check_outputs();
    drive_and_step(ack_pct, rdy_pct, stall_pct, redir_pct);
  endtask

  task automatic check_reset_values();
    chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    chk("rst_pc_plus4", bus.pc_plus4, RESET_PC + 32'd4);
    chk("rst_ifid_valid", {31'b0, bus.ifid_valid}, 32'd0);
    chk("rst_ifid_instr", bus.ifid_instr, 32'd0);
    chk("rst_ifid_pcplus4", bus.ifid_pcplus4, 32'd0);
  endtask

  initial begin
    bus.imem_ack = 1'b0; bus.ifid_ready = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0;
    bus.imem_data = '0; bus.next_pc = '0;
    model_reset();
    @(negedge clk);
    check_reset_values();
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    drive_and_step(100, 100, 0, 0);

    // Zero-wait memory, decode always ready: 0,4,8,... one instruction per two cycles
    for (int i = 0; i < 12; i++) cycle(100, 100, 0, 0);
    // Slow memory
    for (int i = 0; i < 150; i++) cycle(25, 100, 0, 0);
    // Back-pressure from decode and hazard stalls
    for (int i = 0; i < 150; i++) cycle(70, 30, 30, 0);
    // Redirect-heavy mix
    for (int i = 0; i < 250; i++) cycle(40, 70, 15, 20);
    // Drive into a stale-fetch drain, then reset asynchronously with an ack pending
    for (int i = 0; i < 100 && !m_stale; i++) cycle(0, 100, 0, 40);
    @(negedge clk);
    check_outputs();
    chk("discard_entered", {31'b0, m_stale}, 32'd1);
    bus.imem_ack = 1'b1; bus.redirect = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_values();
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    drive_and_step(100, 100, 0, 0);
    for (int i = 0; i < 12; i++) cycle(100, 100, 0, 0);
    for (int i = 0; i < 200; i++) cycle(50, 60, 20, 10);
    @(negedge clk);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
